// File: rtl/mmio_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_fifo_pkg
//  Description : Shared types and constants for the MMIO data FIFO.
//  Revision    : 1.0
// ============================================================================
package mmio_fifo_pkg;

    // MMIO address at which the AFU exposes the FIFO status word
    localparam logic [15:0] FIFO_STATUS_ADDR = 16'h0022;

    typedef struct packed {
        logic        ovf;
        logic        udf;
        logic        full;
        logic        empty;
        logic [27:0] rsvd;
        logic [31:0] count;
    } t_fifo_status;

    function automatic t_fifo_status pack_status(
        input logic        ovf,
        input logic        udf,
        input logic        full,
        input logic        empty,
        input logic [31:0] count
    );
        t_fifo_status s;
        s.ovf   = ovf;
        s.udf   = udf;
        s.full  = full;
        s.empty = empty;
        s.rsvd  = '0;
        s.count = count;
        return s;
    endfunction

endpackage : mmio_fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_mem
//  Description : Simple dual-port RAM, one write port and one registered read
//                port with synchronous clear of the read register.
//  Revision    : 1.0
// ============================================================================
module fifo_mem
    import mmio_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 64,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Storage array carries no reset so it maps onto block RAM
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read-before-write: a same-address write in this cycle is not seen
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule : fifo_mem
`default_nettype wire

// File: rtl/mmio_data_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : mmio_data_fifo
//  Description : 64-bit synchronous FIFO behind the MMIO AFU with occupancy,
//                full/empty and sticky overflow/underflow status.
//  Revision    : 1.0
// ============================================================================
module mmio_data_fifo
    import mmio_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int DW    = 64,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [DW-1:0] d,
    input  logic          rd_en,
    output logic [DW-1:0] q,
    output logic          q_valid,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          ovf,
    output logic          udf,
    input  logic          clr_err,
    output logic [63:0]   status
);

    localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          q_valid_q, q_valid_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;

    logic          w_full;
    logic          w_empty;
    logic          w_push_ok;
    logic          w_pop_ok;
    t_fifo_status  w_status;

    assign w_full  = (count_q == C_DEPTH);
    assign w_empty = (count_q == '0);

    // A push into a full FIFO is still taken when a pop frees the slot
    assign w_pop_ok  = rd_en && !w_empty;
    assign w_push_ok = en && (!w_full || rd_en);

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        q_valid_d = w_pop_ok;
        ovf_d     = ovf_q;
        udf_d     = udf_q;

        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_pop_ok) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({w_push_ok, w_pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A fresh error in the clearing cycle keeps its flag set
        if (clr_err) begin
            ovf_d = 1'b0;
            udf_d = 1'b0;
        end
        if (en && !w_push_ok) begin
            ovf_d = 1'b1;
        end
        if (rd_en && w_empty) begin
            udf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            q_valid_q <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            q_valid_q <= q_valid_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    fifo_mem #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_mem (
        .clk     (clk),
        .rst     (rst),
        .we_i    (w_push_ok && !rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (d),
        .re_i    (w_pop_ok),
        .raddr_i (rd_ptr_q),
        .rdata_o (q)
    );

    assign w_status = pack_status(ovf_q, udf_q, w_full, w_empty, 32'(count_q));

    assign q_valid = q_valid_q;
    assign full    = w_full;
    assign empty   = w_empty;
    assign count   = count_q;
    assign ovf     = ovf_q;
    assign udf     = udf_q;
    assign status  = w_status;

endmodule : mmio_data_fifo
`default_nettype wire

// File: tb/tb_mmio_data_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmio_data_fifo
//  Description : Directed self-checking bench for mmio_data_fifo.
//  Revision    : 1.0
// ============================================================================
module tb_mmio_data_fifo;

    localparam int DEPTH = 16;
    localparam int DW    = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic [DW-1:0] d;
    logic          rd_en;
    logic [DW-1:0] q;
    logic          q_valid;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          ovf;
    logic          udf;
    logic          clr_err;
    logic [63:0]   status;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mmio_data_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .d       (d),
        .rd_en   (rd_en),
        .q       (q),
        .q_valid (q_valid),
        .full    (full),
        .empty   (empty),
        .count   (count),
        .ovf     (ovf),
        .udf     (udf),
        .clr_err (clr_err),
        .status  (status)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [63:0] v);
        en = 1'b1;
        d  = v;
        tick;
        en = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [63:0] v);
        rd_en = 1'b1;
        tick;
        rd_en = 1'b0;
        check({tag, "_qv"}, 64'(q_valid), 64'd1);
        check({tag, "_q"}, q, v);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b0; d = '0; rd_en = 1'b0; clr_err = 1'b0;
        tick; tick;
        rst = 1'b0;
        check("rst_empty", 64'(empty), 64'd1);
        check("rst_full", 64'(full), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_q", q, 64'd0);
        check("rst_status", status, 64'h1000_0000_0000_0000);

        // T2 ordering
        push(64'h1); push(64'h2); push(64'h3);
        check("t2_count3", 64'(count), 64'd3);
        check("t2_status", status, 64'h0000_0000_0000_0003);
        pop_expect("t2_p1", 64'h1);
        pop_expect("t2_p2", 64'h2);
        pop_expect("t2_p3", 64'h3);
        tick;
        check("t2_qv_off", 64'(q_valid), 64'd0);
        check("t2_q_hold", q, 64'h3);
        check("t2_count0", 64'(count), 64'd0);

        // T3 full / overflow
        for (int i = 0; i <= 16; i++) push(64'(i));
        check("t3_full", 64'(full), 64'd1);
        check("t3_count", 64'(count), 64'd16);
        check("t3_ovf", 64'(ovf), 64'd1);
        check("t3_status", status, 64'hA000_0000_0000_0010);
        for (int i = 0; i < 16; i++) pop_expect("t3_drain", 64'(i));
        check("t3_empty", 64'(empty), 64'd1);
        check("t3_udf", 64'(udf), 64'd0);
        clr_err = 1'b1; tick; clr_err = 1'b0;
        check("t3_ovf_clr", 64'(ovf), 64'd0);

        // T4 underflow
        rd_en = 1'b1; tick; rd_en = 1'b0;
        check("t4_udf", 64'(udf), 64'd1);
        check("t4_qv", 64'(q_valid), 64'd0);
        check("t4_q_hold", q, 64'd15);
        en = 1'b1; d = 64'h55; rd_en = 1'b1; tick; en = 1'b0; rd_en = 1'b0;
        check("t4_pp_count", 64'(count), 64'd1);
        check("t4_pp_udf", 64'(udf), 64'd1);
        check("t4_pp_qv", 64'(q_valid), 64'd0);
        check("t4_pp_q", q, 64'd15);
        check("t4_status", status, 64'h4000_0000_0000_0001);
        clr_err = 1'b1; tick; clr_err = 1'b0;
        check("t4_udf_clr", 64'(udf), 64'd0);
        pop_expect("t4_p55", 64'h55);
        clr_err = 1'b1; rd_en = 1'b1; tick; clr_err = 1'b0; rd_en = 1'b0;
        check("t4_clr_vs_new", 64'(udf), 64'd1);
        clr_err = 1'b1; tick; clr_err = 1'b0;
        check("t4_udf_clr2", 64'(udf), 64'd0);

        // T5 simultaneous push/pop when full
        for (int i = 0; i < 16; i++) push(64'(i));
        en = 1'b1; d = 64'hAA; rd_en = 1'b1; tick; en = 1'b0; rd_en = 1'b0;
        check("t5_qv", 64'(q_valid), 64'd1);
        check("t5_q", q, 64'd0);
        check("t5_count", 64'(count), 64'd16);
        check("t5_ovf", 64'(ovf), 64'd0);
        for (int i = 1; i < 16; i++) pop_expect("t5_drain", 64'(i));
        pop_expect("t5_aa", 64'hAA);
        check("t5_empty", 64'(empty), 64'd1);

        // T6 pointer wrap with steady occupancy
        push(64'd100); push(64'd101); push(64'd102);
        for (int i = 0; i < 40; i++) begin
            en = 1'b1; d = 64'(103 + i); rd_en = 1'b1;
            tick;
            check("t6_q", q, 64'(100 + i));
            check("t6_count", 64'(count), 64'd3);
        end
        en = 1'b0; rd_en = 1'b0;
        check("t6_ovf", 64'(ovf), 64'd0);
        check("t6_udf", 64'(udf), 64'd0);
        pop_expect("t6_d0", 64'd140);
        pop_expect("t6_d1", 64'd141);
        pop_expect("t6_d2", 64'd142);

        // T1 reset mid-traffic
        rd_en = 1'b1; tick; rd_en = 1'b0;
        push(64'd7); push(64'd8); push(64'd9);
        check("t1_pre_udf", 64'(udf), 64'd1);
        en = 1'b1; d = 64'hBEEF; rd_en = 1'b1; rst = 1'b1;
        tick; tick;
        rst = 1'b0; en = 1'b0; rd_en = 1'b0;
        check("t1_empty", 64'(empty), 64'd1);
        check("t1_full", 64'(full), 64'd0);
        check("t1_count", 64'(count), 64'd0);
        check("t1_q", q, 64'd0);
        check("t1_qv", 64'(q_valid), 64'd0);
        check("t1_ovf", 64'(ovf), 64'd0);
        check("t1_udf", 64'(udf), 64'd0);
        rd_en = 1'b1; tick; rd_en = 1'b0;
        check("t1_post_qv", 64'(q_valid), 64'd0);
        check("t1_post_udf", 64'(udf), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_mmio_data_fifo
`default_nettype wire
